// File: rtl/istream_arbiter.sv
// rtl/istream_arbiter.sv - burst-granular round-robin arbiter sharing one istream channel
// Optional stall-timeout grant revocation is enabled by defining ISTREAM_ARB_TIMEOUT_EN.
module istream_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REQ     = 4,
    parameter int BURST_MAX   = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                          istream_clk,
    input  logic                          istream_rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          istream_valid,
    output logic [DATA_WIDTH-1:0]         istream_data,
    input  logic                          istream_ready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          grant_active,
    output logic                          arb_timeout
);
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [IDW-1:0] last_grant_q, last_grant_d;
    logic [7:0]     beat_cnt_q, beat_cnt_d;
    logic [IDW-1:0] cand, rr_winner;
    logic           rr_found;
    logic           beat, release_burst;

`ifdef ISTREAM_ARB_TIMEOUT_EN
    localparam int SCW = $clog2(TIMEOUT_CYC + 1);
    logic [SCW-1:0] stall_cnt_q, stall_cnt_d;
    logic           timeout_hit;
`endif

    // Search upward from the requester after last_grant, wrapping, so the previous winner is last.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = '0;
        cand      = last_grant_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (cand == IDW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
            if (!rr_found && req_valid[cand]) begin
                rr_found  = 1'b1;
                rr_winner = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_id_d    = grant_id_q;
        last_grant_d  = last_grant_q;
        beat_cnt_d    = beat_cnt_q;
        req_ready     = '0;
        istream_valid = 1'b0;
        istream_data  = '0;
        beat          = 1'b0;
        release_burst = 1'b0;
`ifdef ISTREAM_ARB_TIMEOUT_EN
        stall_cnt_d   = stall_cnt_q;
        timeout_hit   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
`ifdef ISTREAM_ARB_TIMEOUT_EN
                stall_cnt_d = '0;
`endif
                if (rr_found) begin
                    grant_id_d = rr_winner;
                    beat_cnt_d = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                istream_valid = req_valid[grant_id_q];
                if (istream_valid) begin
                    istream_data = req_data[int'(grant_id_q) * DATA_WIDTH +: DATA_WIDTH];
                end
                req_ready[grant_id_q] = istream_ready;
                beat          = istream_valid && istream_ready;
                release_burst = beat && (req_last[grant_id_q] || beat_cnt_q == 8'(BURST_MAX - 1));
                if (release_burst) begin
                    state_d      = IDLE;
                    last_grant_d = grant_id_q;
                    beat_cnt_d   = '0;
                end else if (beat) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                end
`ifdef ISTREAM_ARB_TIMEOUT_EN
                // Only an absent valid counts as a stall; back-pressure from the sink does not.
                if (istream_valid) begin
                    stall_cnt_d = '0;
                end else if (stall_cnt_q == SCW'(TIMEOUT_CYC - 1)) begin
                    timeout_hit  = 1'b1;
                    stall_cnt_d  = '0;
                    state_d      = IDLE;
                    last_grant_d = grant_id_q;
                    beat_cnt_d   = '0;
                end else begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge istream_clk or negedge istream_rst_n) begin
        if (!istream_rst_n) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            last_grant_q <= IDW'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

`ifdef ISTREAM_ARB_TIMEOUT_EN
    always_ff @(posedge istream_clk or negedge istream_rst_n) begin
        if (!istream_rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign arb_timeout = timeout_hit;
`else
    assign arb_timeout = 1'b0;
`endif

    assign grant_id     = grant_id_q;
    assign grant_active = (state_q == BUSY);

endmodule

// File: tb/tb_istream_arbiter.sv
// tb/tb_istream_arbiter.sv - scoreboard bench for istream_arbiter (NUM_REQ=4, BURST_MAX=8)
module tb_istream_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int BM = 8;
    localparam int TO = 64;
`ifdef ISTREAM_ARB_TIMEOUT_EN
    localparam int EXP_TIMEOUTS = 1;
    localparam int HOLD_CYC     = 20;
`else
    localparam int EXP_TIMEOUTS = 0;
    localparam int HOLD_CYC     = 70;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [1:0]    id;
        logic [DW-1:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_last;
    logic [NR-1:0]    req_ready;
    logic             istream_valid;
    logic [DW-1:0]    istream_data;
    logic             istream_ready;
    logic [1:0]       grant_id;
    logic             grant_active;
    logic             arb_timeout;

    beat_t rq [NR][$];
    exp_t  exp_q [$];
    int    checks = 0;
    int    failures = 0;
    int    timeouts_seen = 0;
    logic [NR-1:0] fire;

    istream_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .BURST_MAX  (BM),
        .TIMEOUT_CYC(TO)
    ) dut (
        .istream_clk  (clk),
        .istream_rst_n(rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .istream_valid(istream_valid),
        .istream_data (istream_data),
        .istream_ready(istream_ready),
        .grant_id     (grant_id),
        .grant_active (grant_active),
        .arb_timeout  (arb_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_req(input int i, input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        rq[i].push_back(b);
    endtask

    task automatic expect_beat(input logic [1:0] id, input logic [DW-1:0] d);
        exp_t e;
        e.id   = id;
        e.data = d;
        exp_q.push_back(e);
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < NR; i++) if (rq[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_grant_active"}, 64'(grant_active), 64'd0);
        chk({tag, "_grant_id"}, 64'(grant_id), 64'd0);
        chk({tag, "_istream_valid"}, 64'(istream_valid), 64'd0);
        chk({tag, "_istream_data"}, 64'(istream_data), 64'd0);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_arb_timeout"}, 64'(arb_timeout), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        for (int i = 0; i < NR; i++) rq[i].delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_grant(input string name, input int budget);
        int n = 0;
        @(negedge clk);
        while (!grant_active && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s no grant within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_drain(input string name, input int budget, input bit need_idle);
        int n = 0;
        while ((exp_q.size() != 0 || (need_idle && (grant_active || pending()))) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s drain timeout, %0d beats still expected", name, exp_q.size());
        end
    endtask

    // Requester agents: present queue heads, pop a beat once it has been accepted.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            fire = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (fire[i] && rq[i].size() != 0) void'(rq[i].pop_front());
                req_valid[i] = (rq[i].size() != 0);
                req_data[i*DW +: DW] = (rq[i].size() != 0) ? rq[i][0].data : '0;
                req_last[i] = (rq[i].size() != 0) ? rq[i][0].last : 1'b0;
            end
        end
    end

    // Monitor: every transferred beat is matched against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (istream_valid && istream_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 64'(istream_data), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", 64'(istream_data), 64'(e.data));
                        chk("beat_grant", 64'(grant_id), 64'(e.id));
                    end
                end
                if (!istream_valid) chk("idle_data_zero", 64'(istream_data), 64'd0);
                chk("ungranted_ready", 64'(req_ready & ~(4'b0001 << grant_id)), 64'd0);
                if (arb_timeout) timeouts_seen++;
            end
        end
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int idle;
        int n;
        rst_n = 1'b1;
        istream_ready = 1'b0;
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single 3-beat burst from requester 0.
        istream_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            push_req(0, 32'(32'hA0 + k), k == 2);
            expect_beat(2'd0, 32'(32'hA0 + k));
        end
        @(negedge clk);
        @(negedge clk);
        chk("t1_grant_active", 64'(grant_active), 64'd1);
        chk("t1_grant_id", 64'(grant_id), 64'd0);
        chk("t1_valid_b0", 64'(istream_valid), 64'd1);
        @(negedge clk);
        chk("t1_valid_b1", 64'(istream_valid), 64'd1);
        @(negedge clk);
        chk("t1_valid_b2", 64'(istream_valid), 64'd1);
        @(negedge clk);
        chk("t1_idle_after", 64'(grant_active), 64'd0);
        chk("t1_valid_after", 64'(istream_valid), 64'd0);
        wait_drain("t1", 50, 1'b1);

        // All four requesters with 2-beat bursts: order 0,1,2,3,0 with one idle cycle between.
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 4; k++) push_req(0, 32'(32'h100 + k), k[0]);
        for (int i = 1; i < NR; i++) begin
            for (int k = 0; k < 2; k++) push_req(i, 32'(32'h100 * (i + 1) + k), k[0]);
        end
        expect_beat(2'd0, 32'h100);
        expect_beat(2'd0, 32'h101);
        expect_beat(2'd1, 32'h200);
        expect_beat(2'd1, 32'h201);
        expect_beat(2'd2, 32'h300);
        expect_beat(2'd2, 32'h301);
        expect_beat(2'd3, 32'h400);
        expect_beat(2'd3, 32'h401);
        expect_beat(2'd0, 32'h102);
        expect_beat(2'd0, 32'h103);
        wait_grant("t2", 20);
        idle = 0;
        n = 0;
        #1;
        while (exp_q.size() != 0 && n < 100) begin
            if (!grant_active) idle++;
            @(negedge clk);
            #1;
            n++;
        end
        chk("t2_idle_gaps", 64'(idle), 64'd4);
        wait_drain("t2", 50, 1'b1);

        // BURST_MAX forced re-arbitration between requester 2 (no last) and requester 3.
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 20; k++) push_req(2, 32'(32'h2000 + k), 1'b0);
        for (int k = 0; k < 4; k++) push_req(3, 32'(32'h3000 + k), k[0]);
        for (int k = 0; k < 8; k++) expect_beat(2'd2, 32'(32'h2000 + k));
        expect_beat(2'd3, 32'h3000);
        expect_beat(2'd3, 32'h3001);
        for (int k = 8; k < 16; k++) expect_beat(2'd2, 32'(32'h2000 + k));
        expect_beat(2'd3, 32'h3002);
        expect_beat(2'd3, 32'h3003);
        for (int k = 16; k < 20; k++) expect_beat(2'd2, 32'(32'h2000 + k));
        wait_drain("t3_main", 200, 1'b0);
        // Requester 2 has gone quiet mid-burst: the grant must be held.
        repeat (HOLD_CYC) @(negedge clk);
        chk("t3_hold_active", 64'(grant_active), 64'd1);
        chk("t3_hold_id", 64'(grant_id), 64'd2);
        chk("t3_hold_valid", 64'(istream_valid), 64'd0);
        chk("t3_hold_ready", 64'(req_ready), 64'b0100);
        chk("t3_hold_timeout", 64'(arb_timeout), 64'd0);
        for (int k = 20; k < 24; k++) begin
            push_req(2, 32'(32'h2000 + k), 1'b0);
            expect_beat(2'd2, 32'(32'h2000 + k));
        end
        wait_drain("t3_tail", 100, 1'b1);
        chk("t3_released", 64'(grant_active), 64'd0);
        chk("t3_id_kept", 64'(grant_id), 64'd2);

        // Back-pressure on requester 1: ready pattern 1,0,0,1.
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            push_req(1, 32'(32'hF0 + k), k == 2);
            expect_beat(2'd1, 32'(32'hF0 + k));
        end
        wait_grant("t4", 20);
        chk("t4_grant_id", 64'(grant_id), 64'd1);
        @(posedge clk);
        #1 istream_ready = 1'b0;
        @(negedge clk);
        chk("t4_stall1_valid", 64'(istream_valid), 64'd1);
        chk("t4_stall1_data", 64'(istream_data), 64'hF1);
        chk("t4_stall1_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("t4_stall2_data", 64'(istream_data), 64'hF1);
        chk("t4_stall2_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1 istream_ready = 1'b1;
        wait_drain("t4", 50, 1'b1);

        // Asynchronous reset in the middle of a requester 1 burst.
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            push_req(1, 32'(32'h500 + k), k == 5);
            expect_beat(2'd1, 32'(32'h500 + k));
        end
        wait_grant("t5", 20);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t5_mid");
        for (int i = 0; i < NR; i++) rq[i].delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        push_req(0, 32'h600, 1'b0);
        push_req(0, 32'h601, 1'b1);
        push_req(1, 32'h700, 1'b0);
        push_req(1, 32'h701, 1'b1);
        expect_beat(2'd0, 32'h600);
        expect_beat(2'd0, 32'h601);
        expect_beat(2'd1, 32'h700);
        expect_beat(2'd1, 32'h701);
        wait_drain("t5", 50, 1'b1);

`ifdef ISTREAM_ARB_TIMEOUT_EN
        // Requester 1 stalls after one beat; timeout hands the channel to requester 2.
        do_reset();
        @(negedge clk);
        push_req(1, 32'h800, 1'b0);
        push_req(2, 32'h900, 1'b1);
        expect_beat(2'd1, 32'h800);
        expect_beat(2'd2, 32'h900);
        wait_drain("t6", 200, 1'b1);
`endif

        chk("timeout_pulses", 64'(timeouts_seen), 64'(EXP_TIMEOUTS));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/istream_arbiter.md
Name: istream_arbiter

Overview:
- Shares one istream channel (valid/data/ready toward the DUT) between NUM_REQ upstream requesters.
- Round-robin arbitration at burst granularity: a grant is held until the requester signals last, or BURST_MAX beats have transferred.
- Sits between stimulus/producer agents and the DUT istream input; its output side drives the istream_if signals directly.

Parameters:
- DATA_WIDTH, 32, width of every data bus (matches istream_if).
- NUM_REQ, 4, number of requesters (2..8).
- BURST_MAX, 16, maximum beats per grant before forced re-arbitration (1..255).
- TIMEOUT_CYC, 64, stall cycles before grant revocation (only with ISTREAM_ARB_TIMEOUT_EN).

Ports:
- istream_clk  in  1  clock.
- istream_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester data valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  marks the final beat of a requester burst.
- req_ready  out  NUM_REQ  per-requester accept.
- istream_valid  out  1  to DUT, data valid.
- istream_data  out  DATA_WIDTH  to DUT, data.
- istream_ready  in  1  from DUT, ready to accept.
- grant_id  out  $clog2(NUM_REQ)  currently/last granted requester.
- grant_active  out  1  high while in BUSY.
- arb_timeout  out  1  one-cycle pulse on timeout revocation; tied 0 without the macro.

Behaviour:
- Clock/reset: one clock, istream_clk. Reset istream_rst_n is asynchronous, active-low.
- Reset values: state=IDLE; grant_id=0; last_grant=NUM_REQ-1 (so requester 0 has first priority); beat_cnt=0; stall_cnt=0; all outputs 0.
- Reset asserted mid-burst returns immediately to IDLE; the in-flight burst is abandoned.
- Beat definition: a beat transfers when istream_valid && istream_ready.

State machine:
- IDLE:
  - If any req_valid is high, select the first set bit searching upward from last_grant+1 with wrap.
  - Register the winner into grant_id and go to BUSY.
  - Grant latency: 1 cycle from req_valid to grant_active.
  - No data passes in IDLE: istream_valid=0, req_ready=0.
- BUSY (combinational pass-through of the granted requester):
  - istream_valid = req_valid[grant_id].
  - istream_data = req_data[grant_id] when istream_valid, else 0.
  - req_ready[grant_id] = istream_ready; all other req_ready bits = 0.
- Burst counting: beat_cnt increments on each beat.
- Release: on a beat with req_last[grant_id]=1, or on the beat where beat_cnt reaches BURST_MAX-1:
  - next state IDLE; last_grant<=grant_id; beat_cnt<=0.
- Re-arbitration costs exactly one idle cycle (IDLE) between bursts.
- Granted requester drops valid mid-burst: grant is held and the arbiter waits indefinitely (macro off).
- istream_ready low: beat is held; req_data must stay stable (requester rule); no count change.
- Simultaneous last and BURST_MAX beat: single release, no double update.
- Non-granted requesters' valid/last are ignored; no reordering or buffering inside the block.
- grant_id keeps its value after release until the next grant.

Optional Feature:
- Macro: ISTREAM_ARB_TIMEOUT_EN.
- Defined:
  - In BUSY, stall_cnt counts consecutive cycles with req_valid[grant_id]=0, and clears on any valid cycle.
  - When stall_cnt reaches TIMEOUT_CYC: arb_timeout pulses 1 cycle, state goes to IDLE, last_grant<=grant_id.
- Not defined: no stall counter; arb_timeout is constant 0; the grant is held indefinitely.

Test Plan:
- After reset, req_valid=4'b0001, 3 beats 0xA0..0xA2 with last on the 3rd, istream_ready=1 -> grant_id=0 one cycle later; DUT sees A0,A1,A2 on consecutive cycles; one IDLE cycle follows.
- req_valid=4'b1111 continuously, each requester sending 2-beat bursts -> grant order 0,1,2,3,0; each grant carries exactly 2 beats.
- BURST_MAX=8, requester 2 sends 20 beats with no last, requester 3 also valid -> after 8 beats grant switches to 3; requester 2 resumes after 3 releases.
- Requester 1 granted, istream_ready toggles 1,0,0,1 -> beats transfer only on ready=1; data held; beat_cnt advances by 2.
- Assert istream_rst_n=0 mid-burst on requester 1 -> all outputs 0 asynchronously; after release requester 0 wins if valid.
- Macro on, TIMEOUT_CYC=64, granted requester drops valid for 64 cycles -> arb_timeout pulses once; next valid requester granted. Macro off -> grant held, arb_timeout stays 0.
